// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel divider, h/v counters, sync/blank with a short
// alignment pipe, and a per-frame start pulse with frame counter.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIX_DIV  = 2,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic       vga_clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:1] x_pos,
  output logic [9:1] y_pos,
  output logic       active,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [1:0] DivMax  = 2'(PIX_DIV - 1);
  localparam logic [9:0] HMax    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VMax    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HAct    = 10'(H_ACTIVE);
  localparam logic [9:0] VAct    = 10'(V_ACTIVE);
  localparam logic [9:0] HsStart = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HsEnd   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VsStart = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VsEnd   = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Pipe word layout: {hsync, vsync, video_on}
  localparam logic [2:0] PipeIdle = {~SYNC_POL, ~SYNC_POL, 1'b0};

  logic [1:0] div_cnt_q, div_cnt_d;
  logic       pix_tick_q, pix_tick_d;
  logic [9:0] h_cnt_q, h_cnt_d;
  logic [9:0] v_cnt_q, v_cnt_d;
  logic       frame_start_q, frame_start_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    div_cnt_d     = (div_cnt_q == DivMax) ? 2'd0 : div_cnt_q + 2'd1;
    pix_tick_d    = (div_cnt_q == DivMax);
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    if (pix_tick_q) begin
      if (h_cnt_q == HMax) begin
        h_cnt_d = 10'd0;
        if (v_cnt_q == VMax) begin
          v_cnt_d       = 10'd0;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 8'd1;
        end else begin
          v_cnt_d = v_cnt_q + 10'd1;
        end
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (rst) begin
      div_cnt_q     <= 2'd0;
      pix_tick_q    <= 1'b0;
      h_cnt_q       <= 10'd0;
      v_cnt_q       <= 10'd0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      div_cnt_q     <= div_cnt_d;
      pix_tick_q    <= pix_tick_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  logic active_raw, hsync_raw, vsync_raw;

  always_comb begin
    active_raw = (h_cnt_q < HAct) && (v_cnt_q < VAct);
    hsync_raw  = ((h_cnt_q >= HsStart) && (h_cnt_q < HsEnd)) ? SYNC_POL : ~SYNC_POL;
    vsync_raw  = ((v_cnt_q >= VsStart) && (v_cnt_q < VsEnd)) ? SYNC_POL : ~SYNC_POL;
  end

  logic [2:0] pipe_in, pipe_out;
  assign pipe_in = {hsync_raw, vsync_raw, active_raw};

  // Delay matches the controller's one-cycle character ROM, so it runs on every vga_clk.
  if (PIPE_DLY == 0) begin : g_no_pipe
    assign pipe_out = pipe_in;
  end else begin : g_pipe
    logic [2:0] stage_q [PIPE_DLY];
    always_ff @(posedge vga_clk) begin
      if (rst) begin
        for (int i = 0; i < int'(PIPE_DLY); i++) stage_q[i] <= PipeIdle;
      end else begin
        stage_q[0] <= pipe_in;
        for (int i = 1; i < int'(PIPE_DLY); i++) stage_q[i] <= stage_q[i-1];
      end
    end
    assign pipe_out = stage_q[PIPE_DLY-1];
  end

  assign pix_tick    = pix_tick_q;
  assign active      = active_raw;
  assign x_pos       = active_raw ? h_cnt_q[9:1] : 9'd0;
  assign y_pos       = active_raw ? v_cnt_q[8:0] : 9'd0;
  assign hsync       = pipe_out[2];
  assign vsync       = pipe_out[1];
  assign video_on    = pipe_out[0];
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny-raster instance share
// one clock and reset; a cycle model feeds per-instance expectation queues.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb, div, dly;
    bit pol;
  } cfg_t;

  typedef struct {
    int div, h, v, fc;
    bit pt, fs;
    logic [3:0][2:0] pipe;
  } st_t;

  typedef struct {
    bit pt, act, vo, hs, vs, fs;
    int x, y, fc;
  } out_t;

  localparam cfg_t CfgDef   = '{ha: 640, hf: 16, hs: 96, hb: 48, va: 480, vf: 10, vs: 2,
                                vb: 33, div: 2, dly: 1, pol: 1'b0};
  localparam cfg_t CfgSmall = '{ha: 4, hf: 1, hs: 1, hb: 1, va: 2, vf: 1, vs: 1,
                                vb: 1, div: 1, dly: 2, pol: 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       pt_d, act_d, vo_d, hs_d, vs_d, fs_d;
  logic [9:1] x_d, y_d;
  logic [7:0] fc_d;
  logic       pt_s, act_s, vo_s, hs_s, vs_s, fs_s;
  logic [9:1] x_s, y_s;
  logic [7:0] fc_s;

  vga_timing_gen u_def (
    .vga_clk(clk), .rst(rst), .pix_tick(pt_d), .x_pos(x_d), .y_pos(y_d), .active(act_d),
    .video_on(vo_d), .hsync(hs_d), .vsync(vs_d), .frame_start(fs_d), .frame_cnt(fc_d)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1), .V_ACTIVE(2), .V_FP(1), .V_SYNC(1),
    .V_BP(1), .PIX_DIV(1), .SYNC_POL(1'b1), .PIPE_DLY(2)
  ) u_small (
    .vga_clk(clk), .rst(rst), .pix_tick(pt_s), .x_pos(x_s), .y_pos(y_s), .active(act_s),
    .video_on(vo_s), .hsync(hs_s), .vsync(vs_s), .frame_start(fs_s), .frame_cnt(fc_s)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] raw_of(st_t s, cfg_t c);
    bit act, hsr, vsr;
    act = (s.h < c.ha) && (s.v < c.va);
    hsr = (s.h >= c.ha + c.hf && s.h < c.ha + c.hf + c.hs) ? c.pol : ~c.pol;
    vsr = (s.v >= c.va + c.vf && s.v < c.va + c.vf + c.vs) ? c.pol : ~c.pol;
    return {hsr, vsr, act};
  endfunction

  function automatic st_t step(st_t s, cfg_t c, bit r);
    st_t n;
    int  ht, vt;
    ht = c.ha + c.hf + c.hs + c.hb;
    vt = c.va + c.vf + c.vs + c.vb;
    n  = s;
    if (r) begin
      n.div = 0; n.h = 0; n.v = 0; n.fc = 0; n.pt = 0; n.fs = 0;
      for (int i = 0; i < 4; i++) n.pipe[i] = {~c.pol, ~c.pol, 1'b0};
      return n;
    end
    n.pipe[0] = raw_of(s, c);
    for (int i = 1; i < 4; i++) n.pipe[i] = s.pipe[i-1];
    n.fs = s.pt && (s.h == ht - 1) && (s.v == vt - 1);
    if (n.fs) n.fc = (s.fc + 1) % 256;
    if (s.pt) begin
      if (s.h == ht - 1) begin
        n.h = 0;
        n.v = (s.v == vt - 1) ? 0 : s.v + 1;
      end else begin
        n.h = s.h + 1;
      end
    end
    n.pt  = (s.div == c.div - 1);
    n.div = (s.div == c.div - 1) ? 0 : s.div + 1;
    return n;
  endfunction

  function automatic out_t outs(st_t s, cfg_t c);
    out_t       o;
    logic [2:0] raw, dl;
    raw  = raw_of(s, c);
    dl   = (c.dly == 0) ? raw : s.pipe[c.dly-1];
    o.pt = s.pt;
    o.act = raw[0];
    o.x  = raw[0] ? s.h / 2 : 0;
    o.y  = raw[0] ? s.v % 512 : 0;
    o.hs = dl[2];
    o.vs = dl[1];
    o.vo = dl[0];
    o.fs = s.fs;
    o.fc = s.fc;
    return o;
  endfunction

  st_t  st_def, st_small;
  out_t q_def[$];
  out_t q_small[$];

  // Drive one cycle's reset value on the falling edge and queue the post-edge expectation.
  task automatic tick(input bit r);
    @(negedge clk);
    rst      = r;
    st_def   = step(st_def, CfgDef, r);
    st_small = step(st_small, CfgSmall, r);
    q_def.push_back(outs(st_def, CfgDef));
    q_small.push_back(outs(st_small, CfgSmall));
  endtask

  int cyc = 0;
  int def_fall = -1;
  int def_low  = -1;
  bit def_hs_prev = 1'b1;
  int small_last_fs = -1;
  int small_frames  = 0;

  always @(posedge clk) begin
    out_t e;
    #1;
    cyc++;
    if (q_def.size() > 0) begin
      e = q_def.pop_front();
      check("def.pix_tick", 32'(pt_d), 32'(e.pt));
      check("def.x_pos", 32'(x_d), 32'(e.x));
      check("def.y_pos", 32'(y_d), 32'(e.y));
      check("def.active", 32'(act_d), 32'(e.act));
      check("def.video_on", 32'(vo_d), 32'(e.vo));
      check("def.hsync", 32'(hs_d), 32'(e.hs));
      check("def.vsync", 32'(vs_d), 32'(e.vs));
      check("def.frame_start", 32'(fs_d), 32'(e.fs));
      check("def.frame_cnt", 32'(fc_d), 32'(e.fc));
    end
    if (q_small.size() > 0) begin
      e = q_small.pop_front();
      check("small.pix_tick", 32'(pt_s), 32'(e.pt));
      check("small.x_pos", 32'(x_s), 32'(e.x));
      check("small.y_pos", 32'(y_s), 32'(e.y));
      check("small.active", 32'(act_s), 32'(e.act));
      check("small.video_on", 32'(vo_s), 32'(e.vo));
      check("small.hsync", 32'(hs_s), 32'(e.hs));
      check("small.vsync", 32'(vs_s), 32'(e.vs));
      check("small.frame_start", 32'(fs_s), 32'(e.fs));
      check("small.frame_cnt", 32'(fc_s), 32'(e.fc));
    end
    // Line-level properties measured directly on the outputs.
    if (rst) begin
      def_fall = -1; def_low = -1; small_last_fs = -1; small_frames = 0;
      def_hs_prev = 1'b1;
    end else begin
      if (def_hs_prev && !hs_d) begin
        if (def_fall >= 0) check("def.line_period", 32'(cyc - def_fall), 32'd1600);
        def_fall = cyc;
        def_low  = cyc;
      end
      if (!def_hs_prev && hs_d && def_low >= 0) check("def.hsync_low", 32'(cyc - def_low), 32'd192);
      def_hs_prev = hs_d;
      if (fs_s) begin
        small_frames++;
        if (small_last_fs >= 0) check("small.frame_period", 32'(cyc - small_last_fs), 32'd35);
        small_last_fs = cyc;
        check("small.fc_track", 32'(fc_s), 32'(small_frames % 256));
        if (small_frames == 256) check("small.fc_wrap", 32'(fc_s), 32'd0);
      end
    end
  end

  initial begin
    int guard;
    for (int i = 0; i < 3; i++) tick(1'b1);
    tick(1'b0);
    check("rst.hsync", 32'(hs_d), 32'd1);
    check("rst.vsync", 32'(vs_d), 32'd1);
    check("rst.video_on", 32'(vo_d), 32'd0);
    check("rst.frame_cnt", 32'(fc_d), 32'd0);
    check("rst.pix_tick", 32'(pt_d), 32'd0);
    check("rst.small_hsync", 32'(hs_s), 32'd0);
    tick(1'b0);
    check("rel1.pix_tick", 32'(pt_d), 32'd0);
    tick(1'b0);
    check("rel2.pix_tick", 32'(pt_d), 32'd1);
    check("rel2.small_pix_tick", 32'(pt_s), 32'd1);

    for (int i = 0; i < 9100; i++) tick(1'b0);
    check("small.frames_seen", 32'(small_frames >= 256), 32'd1);

    // Reset in the middle of a default-instance hsync pulse.
    guard = 0;
    while (st_def.h != 700 && guard < 4000) begin
      tick(1'b0);
      guard++;
    end
    check("midrst.found_h700", 32'(st_def.h == 700), 32'd1);
    tick(1'b0);
    check("midrst.hsync_before", 32'(hs_d), 32'd0);
    tick(1'b1);
    tick(1'b0);
    check("midrst.hsync", 32'(hs_d), 32'd1);
    check("midrst.active", 32'(act_d), 32'd1);
    check("midrst.x_pos", 32'(x_d), 32'd0);
    check("midrst.frame_start", 32'(fs_d), 32'd0);
    check("midrst.frame_cnt", 32'(fc_d), 32'd0);
    check("midrst.small_fc", 32'(fc_s), 32'd0);
    for (int i = 0; i < 60; i++) tick(1'b0);
    @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
